// File: rtl/pa_riscv_pkg.sv
// Shared RV32I definitions: opcodes, control-unit state and datapath select encodings.
package pa_riscv;

  localparam logic [6:0] OP_LW         = 7'b0000011;
  localparam logic [6:0] OP_SW         = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE_ALU = 7'b0110011;
  localparam logic [6:0] OP_B_TYPE     = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE_ALU = 7'b0010011;
  localparam logic [6:0] OP_JAL        = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_READDATA = 2'b01, RES_ALURESULT = 2'b10} result_src_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic imm_src_e imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:     return IMM_S;
      OP_B_TYPE: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus instruction funct fields onto the ALU operation code.
module alu_decoder
  import pa_riscv::*;
(
  input  alu_op_e    i_aluOp,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_opcode5,
  output logic [2:0] o_aluControl
);

  alu_ctrl_e alu_ctrl;

  // Fixed add/sub requests pass straight through; funct requests decode funct3.
  // instr[30] only selects sub for register-register ops (opcode[5]=1), never for addi.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (i_aluOp)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  alu_ctrl = (i_funct7b5 & i_opcode5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign o_aluControl = alu_ctrl;

endmodule

// File: rtl/multicycle_control.sv
// Main FSM of the multicycle RV32I core: sequences the shared datapath per instruction.
module multicycle_control
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_immSrc,
  output logic [2:0] o_aluControl,
  output logic       o_retire,
  output logic       o_illegal
);

  state_e      state_q, state_d;
  alu_op_e     alu_op;
  alu_src_a_e  src_a;
  alu_src_b_e  src_b;
  result_src_e result_src;
  logic        adr_src, pc_update, branch, ir_write, mem_write, reg_write, retire, illegal;

  // State register; reset returns to FETCH at once, abandoning any instruction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next state and raw per-state control values.
  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (i_memReady) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target OldPC+imm is parked in ALUOut here.
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (i_opcode)
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_R_TYPE_ALU: state_d = S_EXECUTER;
          OP_I_TYPE_ALU: state_d = S_EXECUTEI;
          OP_B_TYPE:     state_d = S_BEQ;
          OP_JAL:        state_d = S_JAL;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        state_d = (i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (i_memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (i_memReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTER: begin
        src_a   = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a   = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluOp      (alu_op),
    .i_funct3     (i_funct3),
    .i_funct7b5   (i_funct7b5),
    .i_opcode5    (i_opcode[5]),
    .o_aluControl (o_aluControl)
  );

  // Enables are gated by reset directly so they drop the instant reset asserts.
  assign o_pcWrite   = i_rst_n & (pc_update | (branch & i_zero));
  assign o_irWrite   = i_rst_n & ir_write;
  assign o_memWrite  = i_rst_n & mem_write;
  assign o_regWrite  = i_rst_n & reg_write;
  assign o_retire    = i_rst_n & retire;
  assign o_illegal   = i_rst_n & illegal;
  assign o_adrSrc    = adr_src;
  assign o_resultSrc = result_src;
  assign o_aluSrcA   = src_a;
  assign o_aluSrcB   = src_b;
  assign o_immSrc    = imm_src_of(i_opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level checks of multicycle_control against a timing/count model.
module tb_multicycle_control;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5, i_zero, i_memReady;
  logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_retire, o_illegal;
  logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [2:0] o_aluControl;

  int n_cmp = 0;
  int n_err = 0;

  localparam int T_LW = 0, T_SW = 1, T_R = 2, T_I = 3, T_BEQ = 4, T_JAL = 5;

  multicycle_control dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_memReady(i_memReady),
    .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
    .o_irWrite(o_irWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
    .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_immSrc(o_immSrc),
    .o_aluControl(o_aluControl), .o_retire(o_retire), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] opcode_of(input int t);
    case (t)
      T_LW:    return 7'b0000011;
      T_SW:    return 7'b0100011;
      T_R:     return 7'b0110011;
      T_I:     return 7'b0010011;
      T_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input int t);
    case (t)
      T_SW:    return 2'b01;
      T_BEQ:   return 2'b10;
      T_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation expected in the cycle right after DECODE.
  function automatic logic [2:0] exp_alu(input int t, input logic [2:0] f3, input logic f7);
    if (t == T_BEQ) return 3'b001;
    if (t != T_R && t != T_I) return 3'b000;
    case (f3)
      3'b000:  return (f7 && t == T_R) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Runs one instruction starting in FETCH just after a falling edge.
  // wf = FETCH wait cycles, wm = memory-phase wait cycles, zb = i_zero in the cycle after DECODE.
  task automatic run_instr(input int t, input logic [2:0] f3, input logic f7,
                           input int wf, input int wm, input logic zb);
    int len, exec_idx, mem_start;
    int c_ir, c_reg, c_mem, c_pc, c_ret, ir_at, ret_at, imm_bad;
    logic [1:0] rs_at_reg;
    logic [2:0] alu_at_exec;
    logic       pc_at_exec;
    bit         is_mem;
    c_ir = 0; c_reg = 0; c_mem = 0; c_pc = 0; c_ret = 0; ir_at = -1; ret_at = -1; imm_bad = 0;
    rs_at_reg = 2'b11; alu_at_exec = 3'b111; pc_at_exec = 1'bx;
    is_mem    = (t == T_LW || t == T_SW);
    exec_idx  = wf + 2;
    mem_start = wf + 3;
    case (t)
      T_LW:    len = wf + wm + 5;
      T_SW:    len = wf + wm + 4;
      T_BEQ:   len = wf + 3;
      default: len = wf + 4;
    endcase
    i_opcode   = opcode_of(t);
    i_funct3   = f3;
    i_funct7b5 = f7;
    for (int k = 0; k < len; k++) begin
      if (k < wf) i_memReady = 1'b0;
      else if (k == wf) i_memReady = 1'b1;
      else if (is_mem && k >= mem_start && k <= mem_start + wm) i_memReady = (k == mem_start + wm);
      else i_memReady = 1'($urandom_range(1));
      i_zero = (k == exec_idx) ? zb : 1'($urandom_range(1));
      #1;
      if (o_irWrite) begin c_ir++; ir_at = k; end
      if (o_regWrite) begin c_reg++; rs_at_reg = o_resultSrc; end
      if (o_memWrite) c_mem++;
      if (o_pcWrite) c_pc++;
      if (o_retire) begin c_ret++; ret_at = k; end
      if (o_immSrc !== exp_imm(t)) imm_bad++;
      if (k == exec_idx) begin alu_at_exec = o_aluControl; pc_at_exec = o_pcWrite; end
      @(negedge i_clk);
    end
    check("retire_count", c_ret, 1);
    check("retire_last_cycle", ret_at, len - 1);
    check("irwrite_count", c_ir, 1);
    check("irwrite_cycle", ir_at, wf);
    check("regwrite_count", c_reg, (t == T_SW || t == T_BEQ) ? 0 : 1);
    if (t != T_SW && t != T_BEQ) check("regwrite_resultsrc", rs_at_reg, (t == T_LW) ? 2'b01 : 2'b00);
    check("memwrite_count", c_mem, (t == T_SW) ? wm + 1 : 0);
    check("pcwrite_count", c_pc, 1 + ((t == T_JAL) ? 1 : 0) + ((t == T_BEQ && zb) ? 1 : 0));
    check("pcwrite_after_decode", pc_at_exec, (t == T_JAL) || (t == T_BEQ && zb));
    check("alucontrol_after_decode", alu_at_exec, exp_alu(t, f3, f7));
    check("immsrc_cycles_wrong", imm_bad, 0);
    $display("instr type=%0d op=%b f3=%b f7b5=%b wf=%0d wm=%0d zero=%b cycles=%0d",
             t, opcode_of(t), f3, f7, wf, wm, zb, len);
  endtask

  initial begin
    i_rst_n = 1'b0; i_opcode = 7'b0110011; i_funct3 = 3'b000; i_funct7b5 = 1'b0;
    i_zero = 1'b1; i_memReady = 1'b1;
    #1;
    check("rst_pcwrite", o_pcWrite, 0);
    check("rst_irwrite", o_irWrite, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_adrsrc", o_adrSrc, 0);
    check("rst_srcb", o_aluSrcB, 2'b10);
    check("rst_resultsrc", o_resultSrc, 2'b10);
    repeat (2) @(negedge i_clk);
    check("rst_hold_irwrite", o_irWrite, 0);
    i_rst_n = 1'b1;

    // Directed cases.
    run_instr(T_R,   3'b000, 1'b0, 0, 0, 1'b0);   // add
    run_instr(T_R,   3'b000, 1'b1, 0, 0, 1'b0);   // sub
    run_instr(T_I,   3'b000, 1'b1, 0, 0, 1'b0);   // addi with instr[30]=1
    run_instr(T_LW,  3'b010, 1'b0, 2, 3, 1'b0);   // lw, 10 cycles
    run_instr(T_BEQ, 3'b000, 1'b0, 0, 0, 1'b1);   // taken
    run_instr(T_BEQ, 3'b000, 1'b0, 0, 0, 1'b0);   // not taken
    run_instr(T_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(T_SW,  3'b010, 1'b0, 1, 2, 1'b0);

    // Random instruction mix.
    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(5)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)));

    // Reset in the middle of a store's memory wait.
    i_opcode = 7'b0100011; i_memReady = 1'b1;
    @(negedge i_clk);                 // FETCH -> DECODE
    i_memReady = 1'b0;
    @(negedge i_clk);                 // DECODE -> MEMADR
    @(negedge i_clk);                 // MEMADR -> MEMWRITE
    #1;
    check("sw_memwrite_before_rst", o_memWrite, 1);
    check("sw_adrsrc_before_rst", o_adrSrc, 1);
    #1 i_rst_n = 1'b0;
    #1;
    check("rst_mid_sw_memwrite", o_memWrite, 0);
    check("rst_mid_sw_retire", o_retire, 0);
    check("rst_mid_sw_adrsrc", o_adrSrc, 0);
    check("rst_mid_sw_srcb", o_aluSrcB, 2'b10);
    @(negedge i_clk);
    check("rst_mid_sw_held", o_memWrite, 0);
    i_rst_n = 1'b1;
    run_instr(T_R, 3'b000, 1'b0, 0, 0, 1'b0);

    // Unsupported opcode locks up until reset.
    i_opcode = 7'b0000000; i_memReady = 1'b1;
    #1;
    check("illegal_fetch_ir", o_irWrite, 1);
    @(negedge i_clk);
    #1;
    check("illegal_flag_in_decode", o_illegal, 0);
    @(negedge i_clk);
    for (int k = 0; k < 20; k++) begin
      i_memReady = 1'($urandom_range(1));
      i_zero     = 1'($urandom_range(1));
      i_opcode   = opcode_of(int'($urandom_range(5)));
      #1;
      check("illegal_flag", o_illegal, 1);
      check("illegal_enables", {o_pcWrite, o_irWrite, o_memWrite, o_regWrite, o_retire}, 5'b0);
      @(negedge i_clk);
    end
    $display("instr type=illegal op=0000000 held=20");
    i_rst_n = 1'b0;
    #1;
    check("illegal_cleared_by_rst", o_illegal, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_instr(T_I, 3'b110, 1'b0, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RV32I core. It sequences the shared datapath (one memory, one ALU, immediate extender, register file) through fetch, decode, execute, memory and writeback states per instruction. It decodes the opcode into the extender's immediate-format select and the ALU operation, and waits on a memory ready handshake. It sits beside the datapath and drives every enable and mux select in it.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_opcode  in  7  instruction[6:0] from the instruction register.
- i_funct3  in  3  instruction[14:12].
- i_funct7b5  in  1  instruction[30].
- i_zero  in  1  ALU zero flag.
- i_memReady  in  1  memory has completed the current read or write this cycle.
- o_pcWrite  out  1  PC register enable.
- o_adrSrc  out  1  memory address mux: 0 = PC, 1 = Result.
- o_memWrite  out  1  memory write strobe.
- o_irWrite  out  1  instruction register and OldPC enable.
- o_regWrite  out  1  register file write enable.
- o_resultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult.
- o_aluSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
- o_aluSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- o_immSrc  out  2  extender format: 00 I, 01 S, 10 B, 11 J.
- o_aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- o_retire  out  1  one-cycle pulse on an instruction's final cycle.
- o_illegal  out  1  sticky unsupported-opcode flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL.
- FETCH outputs:
  - adrSrc 0, srcA 00, srcB 10, add, resultSrc 10.
  - irWrite and pcUpdate are asserted only in the cycle i_memReady=1; the state advances to DECODE in that same cycle.
  - While i_memReady=0, the FSM holds in FETCH with both enables low.
- DECODE:
  - srcA 01, srcB 01, add; this computes the branch/jump target into ALUOut.
  - Transitions by opcode: lw or sw → MEMADR; R-type → EXECUTER; I-type ALU → EXECUTEI; beq → BEQ; jal → JAL; anything else → ILLEGAL.
- MEMADR: srcA 10, srcB 01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc 1, resultSrc 00. Holds until i_memReady, then → MEMWB.
- MEMWB: resultSrc 01, regWrite, retire. → FETCH.
- MEMWRITE: adrSrc 1, resultSrc 00, memWrite held high until the i_memReady cycle (inclusive); retire in that cycle. → FETCH.
- EXECUTER: srcA 10, srcB 00, ALUOp funct. → ALUWB.
- EXECUTEI: srcA 10, srcB 01, ALUOp funct. → ALUWB.
- ALUWB: resultSrc 00, regWrite, retire. → FETCH.
- BEQ: srcA 10, srcB 00, sub, resultSrc 00, branch, retire. → FETCH.
- JAL: srcA 01, srcB 10, add, resultSrc 00, pcUpdate. → ALUWB, which writes PC+4 to rd.
- o_pcWrite = pcUpdate | (branch & i_zero).
- o_immSrc is decoded combinationally from i_opcode in every state: lw and I-type ALU → 00, sw → 01, beq → 10, jal → 11, others → 00.
- ALU decode:
  - ALUOp add → 000; sub → 001.
  - ALUOp funct by funct3: 000 → sub if (i_funct7b5 & i_opcode[5]) else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- ILLEGAL: o_illegal=1 and all enables 0. The state is terminal until reset.
- Unasserted enables are 0; selects not listed are 00.

## Timing
- Reset:
  - While i_rst_n=0, state is FETCH.
  - o_pcWrite, o_irWrite, o_memWrite, o_regWrite, o_retire and o_illegal are forced 0.
  - Selects show FETCH values.
  - Assertion mid-instruction aborts it immediately, with no partial writes after reset asserts.
- Outputs are combinational from state and inputs. State registers on the rising edge of i_clk.
- Cycles with zero memory wait: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Each cycle i_memReady is low adds one cycle in FETCH, MEMREAD or MEMWRITE.
- i_memReady is ignored in all other states.
- o_retire and o_pcWrite are never asserted in a FETCH cycle with i_memReady=0.

## Structure
- The shared pa_riscv package gets:
  - the state enum;
  - an added JAL opcode (7'b1101111) beside LW, SW, R_TYPE_ALU, B_TYPE, I_TYPE_ALU;
  - enums for ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp and ALUControl encodings.
- Sub-module alu_decoder (ALUOp, funct3, funct7b5, opcode[5] → aluControl) is instantiated once.
- FSM and output decode stay in multicycle_control.

## Test plan
- Reset pulse mid-MEMWRITE → o_memWrite falls with i_rst_n, without waiting for a clock; after release, state is FETCH.
- add (opcode 0110011, funct3 000, funct7b5 0), memReady tied 1 → 4 cycles; aluControl 000 in EXECUTER; regWrite and retire in cycle 4.
- sub in the same setup with funct7b5 1 → aluControl 001. addi with instr[30]=1 → aluControl 000 (opcode[5]=0).
- lw with memReady low 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total; irWrite exactly once; regWrite once with resultSrc 01.
- beq with i_zero=1 → pcWrite in BEQ cycle, immSrc 10. Repeat with i_zero=0 → no pcWrite; retire=1 in both.
- jal → immSrc 11; pcWrite in JAL; ALUWB writes with resultSrc 00.
- Opcode 0000000 → ILLEGAL after DECODE, o_illegal=1, no enables for 20 cycles; cleared only by reset.
